// File: rtl/serial_compare_word_serializer_if.sv
// Word-pair handshake plus the serial bit stream toward the MSB-first comparator.
interface serial_compare_word_serializer_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         cmp_clear;
  logic         ser_a;
  logic         ser_b;
  logic         ser_valid;
  logic         ser_first;
  logic         ser_last;
  logic         busy;

  // Upstream side / testbench driver.
  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, cmp_clear, ser_a, ser_b, ser_valid, ser_first, ser_last, busy
  );

  // Serializer side.
  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, cmp_clear, ser_a, ser_b, ser_valid, ser_first, ser_last, busy
  );
endinterface

// File: rtl/serial_compare_word_serializer.sv
// Serializer feeding an MSB-first comparator: accepts a word pair, strobes the
// comparator clear for one cycle, then streams both words MSB first over W cycles.
module serial_compare_word_serializer #(
  parameter int unsigned W = 8
) (
  input logic                            clk,
  input logic                            rst,
  serial_compare_word_serializer_if.slave bus
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] CntTop = CntW'(W - 1);

  typedef enum logic [1:0] {StIdle, StClear, StShift} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    sa_q, sa_d;
  logic [W-1:0]    sb_q, sb_d;
  logic            ready;
  logic            xfer;

  // Ready depends on state only; the last SHIFT bit may accept the next pair.
  assign ready       = (state_q == StIdle) || ((state_q == StShift) && (cnt_q == '0));
  assign xfer        = bus.in_valid && ready;
  assign bus.in_ready = ready;

  // State, counter and shift registers; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= CntTop;
      sa_q    <= '0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  // Next-state logic and output decode from registered state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;

    bus.cmp_clear = 1'b0;
    bus.ser_a     = 1'b0;
    bus.ser_b     = 1'b0;
    bus.ser_valid = 1'b0;
    bus.ser_first = 1'b0;
    bus.ser_last  = 1'b0;
    bus.busy      = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          sa_d    = bus.in_a;
          sb_d    = bus.in_b;
          cnt_d   = CntTop;
          state_d = StClear;
        end
      end

      StClear: begin
        bus.cmp_clear = 1'b1;
        state_d       = StShift;
      end

      StShift: begin
        bus.ser_valid = 1'b1;
        bus.ser_a     = sa_q[W-1];
        bus.ser_b     = sb_q[W-1];
        bus.ser_first = (cnt_q == CntTop);
        bus.ser_last  = (cnt_q == '0);
        sa_d          = sa_q << 1;
        sb_d          = sb_q << 1;
        if (cnt_q == '0) begin
          // Back-to-back pair goes straight into its own CLEAR cycle.
          if (xfer) begin
            sa_d    = bus.in_a;
            sb_d    = bus.in_b;
            cnt_d   = CntTop;
            state_d = StClear;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_compare_word_serializer.sv
// Scoreboard bench: accepted pairs are queued at the handshake and checked
// bit by bit as the serializer streams them; a W=1 instance gets direct checks.
module tb_serial_compare_word_serializer;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  logic clk = 1'b0;
  logic rst;
  logic rst1;

  always #5 clk = ~clk;

  serial_compare_word_serializer_if #(.W(W)) bus ();
  serial_compare_word_serializer_if #(.W(1)) bus1 ();

  serial_compare_word_serializer #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  serial_compare_word_serializer #(.W(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard and cycle model of the expected stream.
  pair_t sb_q[$];
  pair_t cur;
  pair_t pushed;
  int    rem = 0;
  int    rem_n;
  int    idx;
  bit    clear_due = 1'b0;
  bit    clear_n;
  bit    exp_clear;
  bit    exp_valid;
  bit    lt_m;
  bit    gt_m;
  int    lasts = 0;

  always @(negedge clk) begin
    exp_clear = clear_due;
    exp_valid = (rem > 0);
    rem_n     = rem;
    clear_n   = 1'b0;

    check_eq("cmp_clear", bus.cmp_clear, exp_clear);
    check_eq("ser_valid", bus.ser_valid, exp_valid);
    check_eq("busy", bus.busy, exp_clear || exp_valid);
    check_eq("in_ready", bus.in_ready, !exp_clear && (rem <= 1));

    if (exp_clear) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", sb_q.size(), 1);
      end else begin
        cur = sb_q.pop_front();
      end
      lt_m  = 1'b0;
      gt_m  = 1'b0;
      rem_n = W;
    end

    if (exp_valid) begin
      idx = rem - 1;
      check_eq("ser_a", bus.ser_a, cur.a[idx]);
      check_eq("ser_b", bus.ser_b, cur.b[idx]);
      check_eq("ser_first", bus.ser_first, idx == W - 1);
      check_eq("ser_last", bus.ser_last, idx == 0);
      // Reference MSB-first comparator fed by the stream.
      if (!lt_m && !gt_m) begin
        if (bus.ser_a && !bus.ser_b) gt_m = 1'b1;
        else if (!bus.ser_a && bus.ser_b) lt_m = 1'b1;
      end
      if (idx == 0) begin
        lasts++;
        check_eq("cmp_lt", lt_m, cur.a < cur.b);
        check_eq("cmp_gt", gt_m, cur.a > cur.b);
        check_eq("cmp_eq", !lt_m && !gt_m, cur.a == cur.b);
      end
      rem_n = rem - 1;
    end else begin
      check_eq("idle_bits", {bus.ser_a, bus.ser_b, bus.ser_first, bus.ser_last}, 0);
    end

    if (bus.in_valid && bus.in_ready && !rst) begin
      pushed.a = bus.in_a;
      pushed.b = bus.in_b;
      sb_q.push_back(pushed);
      clear_n = 1'b1;
    end

    if (rst) begin
      rem_n   = 0;
      clear_n = 1'b0;
    end

    rem       = rem_n;
    clear_due = clear_n;
  end

  // Hold in_valid until the pair is accepted; bounded wait.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit hs;
    hs           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      hs = bus.in_ready && !rst;
      @(posedge clk);
      #1;
    end
    check_eq("send_hs", hs, 1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst           = 1'b1;
    rst1          = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 4'hF;
    bus.in_b      = 4'h0;
    bus1.in_valid = 1'b0;
    bus1.in_a     = 1'b0;
    bus1.in_b     = 1'b0;

    // in_valid high during reset must not be captured.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_busy", bus.busy, 0);
    check_eq("reset_ready", bus.in_ready, 1);
    idle(3);

    // Single pair.
    send(4'b1010, 4'b1001);
    idle(8);

    // Back-to-back with in_valid held high.
    send(4'd3, 4'd3);
    send(4'd2, 4'd5);
    idle(8);

    // Second pair offered during SHIFT waits for the last bit.
    send(4'h9, 4'h6);
    send(4'hF, 4'h0);
    idle(8);

    // Reset in the third SHIFT cycle aborts the word.
    send(4'hC, 4'h3);
    idle(3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("abort_busy", bus.busy, 0);
    check_eq("abort_ready", bus.in_ready, 1);
    check_eq("abort_valid", bus.ser_valid, 0);
    check_eq("abort_clear", bus.cmp_clear, 0);
    send(4'h5, 4'hA);
    idle(8);

    check_eq("word_count", lasts, 6);
    check_eq("sb_empty", sb_q.size(), 0);

    // W=1 instance: CLEAR then a single first+last bit.
    rst1 = 1'b0;
    @(posedge clk);
    #1;
    check_eq("w1_idle_busy", bus1.busy, 0);
    bus1.in_valid = 1'b1;
    bus1.in_a     = 1'b1;
    bus1.in_b     = 1'b0;
    check_eq("w1_ready", bus1.in_ready, 1);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    check_eq("w1_clear", bus1.cmp_clear, 1);
    check_eq("w1_clear_valid", bus1.ser_valid, 0);
    @(posedge clk);
    #1;
    check_eq("w1_valid", bus1.ser_valid, 1);
    check_eq("w1_ser_a", bus1.ser_a, 1);
    check_eq("w1_ser_b", bus1.ser_b, 0);
    check_eq("w1_first", bus1.ser_first, 1);
    check_eq("w1_last", bus1.ser_last, 1);
    check_eq("w1_greater", bus1.ser_a && !bus1.ser_b, 1);
    @(posedge clk);
    #1;
    check_eq("w1_done_busy", bus1.busy, 0);
    check_eq("w1_done_valid", bus1.ser_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_compare_word_serializer.md
Name: serial_compare_word_serializer

Overview:
- Upstream feeder for the MSB-first serial comparator.
- Accepts a pair of W-bit words (a, b) over a valid/ready handshake.
- Issues a one-cycle clear strobe for the comparator's state, then streams both words one bit per cycle, most significant bit first.
- Marks the first and last bit so downstream logic can sample the comparator result on the last bit.

Parameters:
- W, 8, word width in bits; legal range W >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream offers a word pair.
- in_ready  output  1  block can accept a word pair this cycle.
- in_a  input  W  operand A, sampled on handshake.
- in_b  input  W  operand B, sampled on handshake.
- cmp_clear  output  1  one-cycle strobe; drives the comparator's reset so its state returns to "equal".
- ser_a  output  1  current bit of A (MSB first).
- ser_b  output  1  current bit of B (MSB first).
- ser_valid  output  1  ser_a/ser_b carry a real bit this cycle.
- ser_first  output  1  current bit is the MSB (bit W-1).
- ser_last  output  1  current bit is the LSB (bit 0); comparator outputs are final this cycle.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - State goes to IDLE and the bit counter to W-1; shift registers clear to 0.
  - All registered outputs are 0 after the reset edge: cmp_clear, ser_a, ser_b, ser_valid, ser_first, ser_last, busy.
  - While rst is high, no handshake is honoured, even if in_valid and in_ready are both 1.
- States: IDLE, CLEAR, SHIFT.
- Handshake and in_ready:
  - A transfer occurs on a rising edge where in_valid & in_ready & ~rst.
  - in_ready = (state==IDLE) | (state==SHIFT & cnt==0). It is combinational from state only and never depends on in_valid.
- IDLE:
  - Outputs 0.
  - On transfer: capture in_a/in_b into shift registers sa/sb, set cnt=W-1, go to CLEAR.
- CLEAR (exactly 1 cycle):
  - cmp_clear=1; ser_valid=0; ser_a=ser_b=0.
  - Next state is SHIFT.
- SHIFT (exactly W cycles):
  - ser_valid=1; ser_a=sa[W-1], ser_b=sb[W-1].
  - ser_first = (cnt==W-1); ser_last = (cnt==0).
  - Each cycle: sa/sb shift left by 1 with 0 fill; cnt decrements.
  - At cnt==0: if a transfer occurs, load new words, cnt=W-1, go to CLEAR (back-to-back). Otherwise go to IDLE.
- Outputs are driven from state and registers; ser_* change only at clock edges.
- Timing:
  - Latency from accepting edge to first ser_valid: 2 cycles (the CLEAR cycle, then the MSB).
  - Word period in continuous streaming: W+1 cycles; throughput is one pair per W+1 cycles.
- Downstream contract: the comparator's result is valid and must be sampled in the cycle ser_last=1. The comparator advances every clock, so any bits seen outside SHIFT are don't-care; CLEAR restores its state before every word.
- W=1: SHIFT lasts 1 cycle with ser_first=ser_last=1.
- in_valid held high in CLEAR or mid-SHIFT: not accepted (in_ready=0). in_a/in_b may change freely without effect.
- Reset mid-CLEAR or mid-SHIFT: the word is aborted.
  - State goes to IDLE on that edge; no ser_last is produced for the aborted word.
  - cmp_clear is not asserted by the abort; the next accepted word gets its own CLEAR.
- Counter width: $clog2(W) bits, minimum 1. cnt never wraps below 0, because the state leaves SHIFT at 0.

Test Plan:
- W=4, single pair a=4'b1010, b=4'b1001:
  - Accepted at edge 0.
  - Cycle 1: cmp_clear=1.
  - Cycles 2-5: ser_a 1,0,1,0 and ser_b 1,0,0,1; ser_first at cycle 2, ser_last at cycle 5.
  - Cycle 6: busy=0.
- Back-to-back, W=4, in_valid held high with pairs (3,3) then (2,5):
  - in_ready=1 only in IDLE and on ser_last cycles.
  - Second CLEAR immediately follows the first word's ser_last; each word period is 5 cycles.
  - The attached comparator gives eq=1 at the first ser_last and less=1 at the second.
- Backpressure, W=4: in_valid asserted during SHIFT (cnt=2) -> no capture and in_ready=0; capture occurs at cnt==0.
- Reset mid-operation, W=8: assert rst during the 3rd SHIFT cycle -> next cycle all outputs 0, busy=0, in_ready=1, no ser_last. A new pair then streams correctly.
- W=1, a=1, b=0 -> CLEAR, then one SHIFT cycle with ser_a=1, ser_b=0, ser_first=ser_last=1; the comparator shows greater=1.
- Reset interaction: in_valid=1 with rst=1 for 2 cycles -> no capture; busy stays 0 after rst deasserts until the next valid edge.
